// File: rtl/string_accel_driver_if.sv
// Job, response and Avalon-MM signals between the string accelerator driver and its neighbours.
// master = driver side, slave = job source / response sink / accelerator side.
interface string_accel_driver_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [2:0]  cmd_len;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [2:0]  acc_address;
   logic        acc_chipselect;
   logic        acc_write;
   logic        acc_read;
   logic [31:0] acc_writedata;
   logic [31:0] acc_readdata;

   modport master (
      input  cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b, rsp_ready, acc_readdata,
      output cmd_ready, rsp_valid, rsp_data, rsp_err,
      output acc_address, acc_chipselect, acc_write, acc_read, acc_writedata
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b, rsp_ready, acc_readdata,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err,
      input  acc_address, acc_chipselect, acc_write, acc_read, acc_writedata
   );
endinterface

// File: rtl/string_accel_driver.sv
// Command sequencer for the String HW Avalon accelerator: one job in, register traffic out, one result back.
// Define STRDRV_TIMEOUT_EN to give up after POLL_MAX unanswered polls and report rsp_err.
module string_accel_driver #(
   parameter int RD_LAT   = 1,
   parameter int POLL_GAP = 4,
   parameter int POLL_MAX = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   string_accel_driver_if.master bus,
   output logic                  busy
);

   // INIT_WR is the cycle in which the post-reset control clear is visible on the bus.
   typedef enum logic [3:0] {
      INIT, INIT_WR, IDLE, WR_A, WR_B, WR_GO, POLL_RD, POLL_WT, POLL_IDLE,
      RES_RD, RES_WT, CLR, RSP
   } state_t;

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
   localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

   state_t      state;
   state_t      stateNext;
   logic [1:0]  latCnt;
   logic [7:0]  gapCnt;
   logic [2:0]  jobOp;
   logic [2:0]  jobLen;
   logic [31:0] jobB;
   logic        acceptJob;
   logic        captureResult;
   logic        timeoutHit;
   logic        wrNext;
   logic        rdNext;
   logic [2:0]  addrNext;
   logic [31:0] dataNext;

`ifdef STRDRV_TIMEOUT_EN
   localparam int POLL_W = $clog2(POLL_MAX + 1);
   localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(POLL_MAX);
   logic [POLL_W-1:0] pollCnt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= INIT;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext     = state;
      acceptJob     = 1'b0;
      captureResult = 1'b0;
      timeoutHit    = 1'b0;
      case (state)
         INIT:    stateNext = INIT_WR;
         INIT_WR: stateNext = IDLE;
         IDLE: begin
            if (bus.cmd_valid && bus.cmd_ready) begin
               acceptJob = 1'b1;
               stateNext = WR_A;
            end
         end
         WR_A:    stateNext = WR_B;
         WR_B:    stateNext = WR_GO;
         WR_GO:   stateNext = POLL_RD;
         POLL_RD: stateNext = POLL_WT;
         POLL_WT: begin
            if (latCnt == LAT_LAST) begin
               if (bus.acc_readdata[0]) begin
                  stateNext = RES_RD;
`ifdef STRDRV_TIMEOUT_EN
               end else if (pollCnt >= POLL_LIMIT) begin
                  timeoutHit = 1'b1;
                  stateNext  = CLR;
`endif
               end else if (POLL_GAP == 0) begin
                  stateNext = POLL_RD;
               end else begin
                  stateNext = POLL_IDLE;
               end
            end
         end
         POLL_IDLE: if (gapCnt == GAP_LAST) stateNext = POLL_RD;
         RES_RD:    stateNext = RES_WT;
         RES_WT: begin
            if (latCnt == LAT_LAST) begin
               captureResult = 1'b1;
               stateNext     = CLR;
            end
         end
         CLR:     stateNext = RSP;
         RSP:     if (bus.rsp_ready) stateNext = IDLE;
         default: stateNext = INIT;
      endcase
   end

   // Bus strobes are decided by the state being entered so they appear, registered, in that state.
   always_comb begin
      wrNext   = 1'b0;
      rdNext   = 1'b0;
      addrNext = 3'd0;
      dataNext = 32'd0;
      case (stateNext)
         INIT_WR: begin wrNext = 1'b1; addrNext = 3'd2; end
         WR_A:    begin wrNext = 1'b1; addrNext = 3'd0; dataNext = bus.cmd_a; end
         WR_B:    begin wrNext = 1'b1; addrNext = 3'd1; dataNext = jobB; end
         WR_GO:   begin wrNext = 1'b1; addrNext = 3'd2; dataNext = {24'd0, jobLen, jobOp, 2'b10}; end
         POLL_RD: begin rdNext = 1'b1; addrNext = 3'd2; end
         RES_RD:  begin rdNext = 1'b1; addrNext = 3'd3; end
         CLR:     begin wrNext = 1'b1; addrNext = 3'd2; dataNext = {24'd0, jobLen, jobOp, 2'b00}; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.acc_write      <= 1'b0;
         bus.acc_read       <= 1'b0;
         bus.acc_chipselect <= 1'b0;
         bus.acc_address    <= 3'd0;
         bus.acc_writedata  <= 32'd0;
         bus.cmd_ready      <= 1'b0;
         bus.rsp_valid      <= 1'b0;
         busy               <= 1'b0;
      end else begin
         bus.acc_write      <= wrNext;
         bus.acc_read       <= rdNext;
         bus.acc_chipselect <= wrNext | rdNext;
         bus.acc_address    <= addrNext;
         bus.acc_writedata  <= dataNext;
         bus.cmd_ready      <= (stateNext == IDLE);
         bus.rsp_valid      <= (stateNext == RSP);
         busy               <= (stateNext != IDLE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         jobOp        <= 3'd0;
         jobLen       <= 3'd0;
         jobB         <= 32'd0;
         bus.rsp_data <= 32'd0;
      end else begin
         if (acceptJob) begin
            jobOp  <= bus.cmd_op;
            jobLen <= bus.cmd_len;
            jobB   <= bus.cmd_b;
         end
         if (captureResult) bus.rsp_data <= bus.acc_readdata;
         else if (timeoutHit) bus.rsp_data <= 32'd0;
      end
   end

   // Read-latency and poll-gap counters restart every time their wait state is entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latCnt <= 2'd0;
         gapCnt <= 8'd0;
      end else begin
         latCnt <= (state == POLL_WT || state == RES_WT) ? latCnt + 2'd1 : 2'd0;
         gapCnt <= (state == POLL_IDLE) ? gapCnt + 8'd1 : 8'd0;
      end
   end

`ifdef STRDRV_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pollCnt     <= '0;
         bus.rsp_err <= 1'b0;
      end else begin
         if (state == IDLE) pollCnt <= '0;
         else if (state == POLL_RD && pollCnt != POLL_LIMIT) pollCnt <= pollCnt + 1'b1;
         if (acceptJob) bus.rsp_err <= 1'b0;
         else if (timeoutHit) bus.rsp_err <= 1'b1;
      end
   end
`else
   assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_string_accel_driver.sv
// Directed bench for string_accel_driver: accelerator register model, strobe/response scoreboards.
module tb_string_accel_driver;

   localparam int RD_LAT       = 1;
   localparam int POLL_GAP     = 4;
   localparam int POLL_MAX     = 4;
   localparam int POLL_SPACING = RD_LAT + POLL_GAP + 1;

   typedef struct packed {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] data;
   } strobe_t;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic busy;

   string_accel_driver_if bus ();

   string_accel_driver #(
      .RD_LAT   (RD_LAT),
      .POLL_GAP (POLL_GAP),
      .POLL_MAX (POLL_MAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int      assertCount = 0;
   int      failCount   = 0;
   int      cycle       = 0;
   int      lastPoll    = -1;
   int      doneAfter   = 0;
   strobe_t expStrobes[$];
   rsp_t    expRsp[$];
   strobe_t monExp;

   logic [31:0] modelA      = 32'd0;
   logic [31:0] modelB      = 32'd0;
   logic [31:0] modelCtrl   = 32'd0;
   logic [31:0] modelResult = 32'd0;
   logic [31:0] modelRdData = 32'd0;
   int          pollCount   = 0;

   assign bus.acc_readdata = modelRdData;

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic strobe_t mkStrobe(input logic wr, input logic [2:0] addr, input logic [31:0] data);
      strobe_t s;
      s.wr   = wr;
      s.addr = addr;
      s.data = data;
      return s;
   endfunction

   function automatic logic [31:0] accResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r = 32'd0;
      logic [7:0]  c;
      if (op == 3'd0) begin
         r = (a == b) ? 32'd1 : 32'd0;
      end else if (op == 3'd1 || op == 3'd2) begin
         for (int i = 0; i < 4; i++) begin
            c = a[8*i +: 8];
            if (op == 3'd1 && c >= 8'h61 && c <= 8'h7a) c = c - 8'd32;
            else if (op == 3'd2 && c >= 8'h41 && c <= 8'h5a) c = c + 8'd32;
            r[8*i +: 8] = c;
         end
      end
      return r;
   endfunction

   always @(posedge clk) cycle <= cycle + 1;

   // Accelerator register model with a one-cycle read latency; done appears after doneAfter polls.
   always @(posedge clk) begin
      modelRdData <= 32'd0;
      if (bus.acc_write) begin
         case (bus.acc_address)
            3'd0: modelA <= bus.acc_writedata;
            3'd1: modelB <= bus.acc_writedata;
            3'd2: begin
               modelCtrl <= bus.acc_writedata;
               if (bus.acc_writedata[1]) begin
                  pollCount   <= 0;
                  modelResult <= accResult(bus.acc_writedata[4:2], modelA, modelB);
               end
            end
            default: ;
         endcase
      end else if (bus.acc_read) begin
         if (bus.acc_address == 3'd2) begin
            modelRdData <= {modelCtrl[31:1], (pollCount >= doneAfter)};
            pollCount   <= pollCount + 1;
         end else if (bus.acc_address == 3'd3) begin
            modelRdData <= modelResult;
         end
      end
   end

   // Bus monitor: every strobe is matched in order against the expected register traffic.
   always @(negedge clk) begin
      if (reset) begin
         checkValue("chipselect", bus.acc_chipselect, bus.acc_read | bus.acc_write);
         checkValue("strobe overlap", bus.acc_read & bus.acc_write, 32'd0);
         if (bus.acc_read || bus.acc_write) begin
            if (expStrobes.size() == 0) begin
               checkValue("unexpected strobe", {bus.acc_write, bus.acc_read}, 32'd0);
            end else begin
               monExp = expStrobes.pop_front();
               checkValue("strobe kind", bus.acc_write, monExp.wr);
               checkValue("strobe address", bus.acc_address, monExp.addr);
               checkValue("strobe writedata", bus.acc_writedata, monExp.data);
            end
            if (bus.acc_read && bus.acc_address == 3'd2) begin
               if (lastPoll >= 0) checkValue("poll spacing", cycle - lastPoll, POLL_SPACING);
               lastPoll = cycle;
            end else if (bus.acc_write) begin
               lastPoll = -1;
            end
         end else begin
            checkValue("idle address", bus.acc_address, 32'd0);
            checkValue("idle writedata", bus.acc_writedata, 32'd0);
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] op, input logic [2:0] len, input logic [31:0] a,
                                input logic [31:0] b, input int polls, input bit timeout);
      int   n = 0;
      rsp_t r;
      expStrobes.push_back(mkStrobe(1'b1, 3'd0, a));
      expStrobes.push_back(mkStrobe(1'b1, 3'd1, b));
      expStrobes.push_back(mkStrobe(1'b1, 3'd2, {24'd0, len, op, 2'b10}));
      if (timeout) begin
         for (int i = 0; i < POLL_MAX; i++) expStrobes.push_back(mkStrobe(1'b0, 3'd2, 32'd0));
         r.data    = 32'd0;
         r.err     = 1'b1;
         doneAfter = 1000000;
      end else begin
         for (int i = 0; i <= polls; i++) expStrobes.push_back(mkStrobe(1'b0, 3'd2, 32'd0));
         expStrobes.push_back(mkStrobe(1'b0, 3'd3, 32'd0));
         r.data    = accResult(op, a, b);
         r.err     = 1'b0;
         doneAfter = polls;
      end
      expStrobes.push_back(mkStrobe(1'b1, 3'd2, {24'd0, len, op, 2'b00}));
      expRsp.push_back(r);
      @(negedge clk);
      bus.cmd_op    = op;
      bus.cmd_len   = len;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkValue("cmd accept", bus.cmd_ready, 32'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic checkOutput(input int hold, input int expLatency);
      int   waited = 0;
      rsp_t e;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.rsp_valid && waited < 300);
      checkValue("rsp_valid", bus.rsp_valid, 32'd1);
      if (expLatency > 0) checkValue("latency", waited, expLatency);
      if (expRsp.size() > 0) e = expRsp.pop_front();
      else e = '0;
      checkValue("rsp_data", bus.rsp_data, e.data);
      checkValue("rsp_err", bus.rsp_err, e.err);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkValue("held rsp_valid", bus.rsp_valid, 32'd1);
         checkValue("held rsp_data", bus.rsp_data, e.data);
         checkValue("held cmd_ready", bus.cmd_ready, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      checkValue("rsp_valid drop", bus.rsp_valid, 32'd0);
      checkValue("idle cmd_ready", bus.cmd_ready, 32'd1);
      checkValue("idle busy", busy, 32'd0);
   endtask

   task automatic waitReady();
      int n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkValue("cmd_ready after init", bus.cmd_ready, 32'd1);
   endtask

   task automatic checkResetOutputs();
      checkValue("reset acc_write", bus.acc_write, 32'd0);
      checkValue("reset acc_read", bus.acc_read, 32'd0);
      checkValue("reset chipselect", bus.acc_chipselect, 32'd0);
      checkValue("reset address", bus.acc_address, 32'd0);
      checkValue("reset writedata", bus.acc_writedata, 32'd0);
      checkValue("reset cmd_ready", bus.cmd_ready, 32'd0);
      checkValue("reset rsp_valid", bus.rsp_valid, 32'd0);
      checkValue("reset rsp_data", bus.rsp_data, 32'd0);
      checkValue("reset busy", busy, 32'd0);
   endtask

   initial begin
      int n;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_len   = 3'd0;
      bus.cmd_a     = 32'd0;
      bus.cmd_b     = 32'd0;
      bus.rsp_ready = 1'b0;
      #2 reset = 1'b0;
      #10;
      checkResetOutputs();
      expStrobes.push_back(mkStrobe(1'b1, 3'd2, 32'd0));
      @(negedge clk);
      reset = 1'b1;
      waitReady();
      checkValue("init strobe seen", expStrobes.size(), 32'd0);

      $display("[TB] T1 compare mismatching strings");
      applyStimulus(3'd0, 3'd0, 32'h61626364, 32'h61626361, 1, 1'b0);
      checkOutput(0, 0);

      $display("[TB] T2 compare equal strings, minimum latency");
      applyStimulus(3'd0, 3'd0, 32'h61626364, 32'h61626364, 0, 1'b0);
      checkOutput(0, 9);

      $display("[TB] T3 case conversion");
      applyStimulus(3'd1, 3'd0, 32'h61626364, 32'h00000000, 2, 1'b0);
      checkOutput(0, 0);
      applyStimulus(3'd2, 3'd0, 32'h41424344, 32'h00000000, 0, 1'b0);
      checkOutput(0, 0);
      applyStimulus(3'd1, 3'd4, 32'h6142317a, 32'h12345678, 1, 1'b0);
      checkOutput(0, 0);

      $display("[TB] T4 response back-pressure");
      applyStimulus(3'd0, 3'd4, 32'h77787970, 32'h77787970, 0, 1'b0);
      checkOutput(10, 0);

`ifdef STRDRV_TIMEOUT_EN
      $display("[TB] T5 poll timeout");
      applyStimulus(3'd0, 3'd0, 32'h61626364, 32'h61626364, 0, 1'b1);
      checkOutput(0, 0);
`endif

      $display("[TB] T6 reset during poll wait");
      applyStimulus(3'd0, 3'd0, 32'h31323334, 32'h31323334, 3, 1'b0);
      n = 0;
      while (!bus.acc_read && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkValue("reached poll read", bus.acc_read, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkResetOutputs();
      expStrobes.delete();
      expRsp.delete();
      lastPoll = -1;
      expStrobes.push_back(mkStrobe(1'b1, 3'd2, 32'd0));
      repeat (3) @(negedge clk);
      reset = 1'b1;
      waitReady();
      checkValue("post-reset init strobe seen", expStrobes.size(), 32'd0);

      applyStimulus(3'd2, 3'd0, 32'h48454c4c, 32'h00000000, 1, 1'b0);
      checkOutput(0, 0);

      repeat (5) @(negedge clk);
      checkValue("leftover strobes", expStrobes.size(), 32'd0);
      checkValue("leftover responses", expRsp.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
